// File: rtl/change_dispense_ctrl_if.sv
// Bundle between the credit logic, the coin dispenser and change_dispense_ctrl.
// The module that pays out change uses the slave modport; the upstream/dispenser side uses master.
interface change_dispense_ctrl_if #(
  parameter int AMT_W = 9,
  parameter int CNT_W = 8
);
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             load_inv;
  logic [CNT_W-1:0] inv_q, inv_d, inv_n;
  logic             coin_seen;
  logic             eject_q, eject_d, eject_n;
  logic             busy, done, short, fault;
  logic [AMT_W-1:0] remaining;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;

  modport master (
    output start, amount, load_inv, inv_q, inv_d, inv_n, coin_seen,
    input  eject_q, eject_d, eject_n, busy, done, short, fault, remaining,
           cnt_q, cnt_d, cnt_n
  );

  modport slave (
    input  start, amount, load_inv, inv_q, inv_d, inv_n, coin_seen,
    output eject_q, eject_d, eject_n, busy, done, short, fault, remaining,
           cnt_q, cnt_d, cnt_n
  );
endinterface

// File: rtl/change_dispense_ctrl.sv
// Greedy quarter/dime/nickel change payout with per-coin solenoid pulse and drop-sensor ack.
// Optional jam timeout: define CHANGE_DISPENSE_TIMEOUT_EN.
module change_dispense_ctrl #(
  parameter int AMT_W       = 9,
  parameter int CNT_W       = 8,
  parameter int PULSE_CYC   = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic                  clk,
  input logic                  rst_n,
  change_dispense_ctrl_if.slave bus
);
  localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam logic [AMT_W-1:0] V_Q = AMT_W'(25);
  localparam logic [AMT_W-1:0] V_D = AMT_W'(10);
  localparam logic [AMT_W-1:0] V_N = AMT_W'(5);

  typedef enum logic [2:0] {IDLE, SELECT, FIRE, WAIT_ACK, GAP, DONE} state_t;
  typedef enum logic [1:0] {COIN_Q, COIN_D, COIN_N} coin_t;

  state_t           state;
  coin_t            coin;
  logic             seen;
  logic [PW-1:0]    pcnt;
  logic [AMT_W-1:0] remaining;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
  logic             eject_q, eject_d, eject_n;
  logic             busy, done, short;
  logic             seen_now, pulse_end, ack_go;

  function automatic logic [AMT_W-1:0] coin_val(input coin_t c);
    case (c)
      COIN_Q:  coin_val = V_Q;
      COIN_D:  coin_val = V_D;
      default: coin_val = V_N;
    endcase
  endfunction

  assign seen_now  = seen | bus.coin_seen;
  assign pulse_end = (state == FIRE) && (pcnt == PW'(PULSE_CYC - 1));
  // The coin is booked exactly once, on the edge that enters GAP.
  assign ack_go    = (pulse_end && seen_now) || (state == WAIT_ACK && bus.coin_seen);

`ifdef CHANGE_DISPENSE_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tcnt;
  logic          fault;
  logic          jam;

  assign jam = (state == FIRE || state == WAIT_ACK) &&
               (tcnt == TW'(TIMEOUT_CYC - 1)) && !seen_now;
  assign bus.fault = fault;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign bus.fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      coin      <= COIN_Q;
      seen      <= 1'b0;
      pcnt      <= '0;
      remaining <= '0;
      cnt_q     <= '0;
      cnt_d     <= '0;
      cnt_n     <= '0;
      eject_q   <= 1'b0;
      eject_d   <= 1'b0;
      eject_n   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      short     <= 1'b0;
`ifdef CHANGE_DISPENSE_TIMEOUT_EN
      tcnt      <= '0;
      fault     <= 1'b0;
`endif
    end else begin
      done  <= 1'b0;
      short <= 1'b0;
`ifdef CHANGE_DISPENSE_TIMEOUT_EN
      fault <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.load_inv) begin
            cnt_q <= bus.inv_q;
            cnt_d <= bus.inv_d;
            cnt_n <= bus.inv_n;
          end else if (bus.start) begin
            remaining <= bus.amount;
            busy      <= 1'b1;
            state     <= SELECT;
          end
        end
        SELECT: begin
          seen <= 1'b0;
          pcnt <= '0;
          if (remaining >= V_Q && cnt_q != '0) begin
            coin    <= COIN_Q;
            eject_q <= 1'b1;
            state   <= FIRE;
          end else if (remaining >= V_D && cnt_d != '0) begin
            coin    <= COIN_D;
            eject_d <= 1'b1;
            state   <= FIRE;
          end else if (remaining >= V_N && cnt_n != '0) begin
            coin    <= COIN_N;
            eject_n <= 1'b1;
            state   <= FIRE;
          end else begin
            done  <= 1'b1;
            short <= (remaining != '0);
            state <= DONE;
          end
        end
        FIRE: begin
          if (bus.coin_seen) seen <= 1'b1;
          // An early ack never shortens the pulse; it only skips WAIT_ACK.
          if (pulse_end) begin
            eject_q <= 1'b0;
            eject_d <= 1'b0;
            eject_n <= 1'b0;
            state   <= seen_now ? GAP : WAIT_ACK;
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end
        WAIT_ACK: if (bus.coin_seen) state <= GAP;
        GAP:      state <= SELECT;
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default:  state <= IDLE;
      endcase

      if (ack_go) begin
        remaining <= remaining - coin_val(coin);
        case (coin)
          COIN_Q:  cnt_q <= cnt_q - CNT_W'(1);
          COIN_D:  cnt_d <= cnt_d - CNT_W'(1);
          default: cnt_n <= cnt_n - CNT_W'(1);
        endcase
      end

`ifdef CHANGE_DISPENSE_TIMEOUT_EN
      if (state == SELECT)
        tcnt <= '0;
      else if (state == FIRE || state == WAIT_ACK)
        tcnt <= tcnt + TW'(1);
      // A jammed coin is abandoned unbooked: remaining and counters keep their values.
      if (jam) begin
        eject_q <= 1'b0;
        eject_d <= 1'b0;
        eject_n <= 1'b0;
        done    <= 1'b1;
        short   <= 1'b1;
        fault   <= 1'b1;
        state   <= DONE;
      end
`endif
    end
  end

  assign bus.eject_q   = eject_q;
  assign bus.eject_d   = eject_d;
  assign bus.eject_n   = eject_n;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.short     = short;
  assign bus.remaining = remaining;
  assign bus.cnt_q     = cnt_q;
  assign bus.cnt_d     = cnt_d;
  assign bus.cnt_n     = cnt_n;
endmodule
